// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug loader.
// Holds the host opcodes, the loader state encoding and the default
// memory depths / run-counter width used as parameter defaults.
package dbg_pkg;

  localparam int IMEM_WORDS_DEF = 64;
  localparam int DMEM_WORDS_DEF = 64;
  localparam int CYC_W_DEF      = 16;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_IMEM = 3'd1;
  localparam logic [2:0] OP_WR_DMEM = 3'd2;
  localparam logic [2:0] OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RUNNING = 3'd4,
    S_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/dbg_loader_run_timer.sv
// run_timer: down-counter that times the CPU run window.
// Ports:
//   clk, reset_n  - clock, async active-low reset (count cleared to 0)
//   load          - load load_val this cycle (has priority over enable)
//   enable        - decrement by one while nonzero
//   load_val      - value to load
//   zero          - count is zero
module run_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dbg_loader.sv
// dbg_loader: host-driven debug loader. Accepts one command at a time,
// writes the instruction ROM / data RAM, reads the data RAM, or releases
// the CPU from reset for a counted number of cycles, then returns one
// response per command.
// Ports:
//   clk, reset_n              - clock, async active-low reset
//   cmd_valid/ready/op/addr/data - host command channel (byte address)
//   rsp_valid/ready/data/err  - host response channel
//   imem_we/addr/wdata        - instruction ROM write port (word index)
//   dmem_we/re/addr/wdata/rdata - data RAM port, rdata one cycle after re
//   cpu_reset                 - active-high CPU reset, low only while running
//   dbg_state                 - current loader state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE. Once rsp_valid rises, it and
// rsp_data/rsp_err hold until the edge where rsp_ready is also high.
module dbg_loader
  import dbg_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int CYC_W      = CYC_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  output logic [9:0]  dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  output logic        cpu_reset,
  output logic [2:0]  dbg_state
);

  state_t           state;
  logic             accept;
  logic             imem_bad;
  logic             dmem_bad;
  logic [CYC_W-1:0] run_n;
  logic             run_load;
  logic             run_zero;

  assign accept = cmd_valid && cmd_ready;
  assign run_n  = cmd_data[CYC_W-1:0];

  // Misaligned or beyond-depth word index (full address width, so high
  // address bits cannot alias into range).
  assign imem_bad = (cmd_addr[1:0] != 2'd0) ||
                    ({18'd0, cmd_addr[15:2]} >= 32'(IMEM_WORDS));
  assign dmem_bad = (cmd_addr[2:0] != 3'd0) ||
                    ({19'd0, cmd_addr[15:3]} >= 32'(DMEM_WORDS));

  // Timer holds N-1 so that it reads zero in the Nth running cycle.
  assign run_load = (state == S_IDLE) && accept && (cmd_op == OP_RUN) &&
                    (run_n != '0);

  run_timer #(.W(CYC_W)) u_run_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (run_load),
    .enable   (state == S_RUNNING),
    .load_val (run_n - 1'b1),
    .zero     (run_zero)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_re    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cpu_reset  <= 1'b1;
    end else begin
      // Strobes are single-cycle pulses.
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      dmem_re <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            case (cmd_op)
              OP_NOP: begin
                rsp_valid <= 1'b1;
                state     <= S_RESP;
              end
              OP_WR_IMEM: begin
                if (imem_bad) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end else begin
                  imem_we    <= 1'b1;
                  imem_addr  <= cmd_addr[11:2];
                  imem_wdata <= cmd_data[31:0];
                  state      <= S_WRITE;
                end
              end
              OP_WR_DMEM: begin
                if (dmem_bad) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end else begin
                  dmem_we    <= 1'b1;
                  dmem_addr  <= cmd_addr[12:3];
                  dmem_wdata <= cmd_data;
                  state      <= S_WRITE;
                end
              end
              OP_RD_DMEM: begin
                if (dmem_bad) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end else begin
                  dmem_re   <= 1'b1;
                  dmem_addr <= cmd_addr[12:3];
                  state     <= S_RD_REQ;
                end
              end
              OP_RUN: begin
                // Result is the requested count; parked here while running.
                rsp_data <= {{(64-CYC_W){1'b0}}, run_n};
                if (run_n == '0) begin
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end else begin
                  cpu_reset <= 1'b0;
                  state     <= S_RUNNING;
                end
              end
              default: begin
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= S_RESP;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rsp_data  <= dmem_rdata;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RUNNING: begin
          if (run_zero) begin
            cpu_reset <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: table of single commands with expected response,
// latency and strobe activity, plus hand-written sequences for reset,
// program load / run / readback, and reset during a run.
module tb_dbg_loader;
  import dbg_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [63:0] rsp_data;
  logic        imem_we, dmem_we, dmem_re, cpu_reset;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic [2:0]  dbg_state;

  dbg_loader dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .cpu_reset(cpu_reset), .dbg_state(dbg_state)
  );

  // ---------------- memories and CPU stand-in ----------------
  // The stand-in needs 14 cycles out of reset to compute a*f + d*e + c
  // from RAM words 0..5 and store it in word 6.
  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  int          cpu_cyc = 0;

  always @(posedge clk) begin
    if (imem_we) imem[imem_addr[5:0]] <= imem_wdata;
    if (dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= dmem[dmem_addr[5:0]];
    if (cpu_reset) cpu_cyc <= 0;
    else begin
      cpu_cyc <= cpu_cyc + 1;
      if (cpu_cyc == 13)
        dmem[6] <= $signed(dmem[0]) * $signed(dmem[5]) +
                   $signed(dmem[3]) * $signed(dmem[4]) + $signed(dmem[2]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Per-cycle invariants: strobes one-hot, memories idle while the CPU
  // runs, cpu_reset high outside RUNNING.
  always @(negedge clk) begin
    if (reset_n) begin
      n_cmp++;
      if ((int'(imem_we) + int'(dmem_we) + int'(dmem_re) > 1) ||
          (!cpu_reset && (imem_we || dmem_we || dmem_re)) ||
          (dbg_state != S_RUNNING && !cpu_reset)) begin
        n_fail++;
        $display("FAIL invariant: iwe=%b dwe=%b dre=%b cpu_reset=%b state=%0d",
                 imem_we, dmem_we, dmem_re, cpu_reset, dbg_state);
      end
    end
  end

  // ---------------- driver ----------------
  bit          tk_timeout, tk_stable, tk_idle, tk_err;
  int          tk_lat, tk_iwe_n, tk_dwe_n, tk_dre_n, tk_low_n, tk_scyc;
  logic [63:0] tk_data, tk_swdata;
  logic [9:0]  tk_saddr;

  task automatic run_cmd(input logic [2:0] op, input logic [15:0] addr,
                         input logic [63:0] data, input int hold, input int budget);
    int k;
    bit got;
    tk_timeout = 0; tk_stable = 1; tk_idle = 0; tk_err = 0; tk_lat = 0;
    tk_iwe_n = 0; tk_dwe_n = 0; tk_dre_n = 0; tk_low_n = 0; tk_scyc = 0;
    tk_data = '0; tk_swdata = '0; tk_saddr = '0;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < budget) begin @(negedge clk); k++; end
    if (!cmd_ready) begin tk_timeout = 1; cmd_valid = 1'b0; return; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    got = 0;
    for (k = 1; k <= budget && !got; k++) begin
      @(negedge clk);
      if (imem_we) begin
        tk_iwe_n++;
        if (tk_scyc == 0) begin tk_scyc = k; tk_saddr = imem_addr; tk_swdata = {32'd0, imem_wdata}; end
      end
      if (dmem_we) begin
        tk_dwe_n++;
        if (tk_scyc == 0) begin tk_scyc = k; tk_saddr = dmem_addr; tk_swdata = dmem_wdata; end
      end
      if (dmem_re) begin
        tk_dre_n++;
        if (tk_scyc == 0) begin tk_scyc = k; tk_saddr = dmem_addr; end
      end
      if (!cpu_reset) tk_low_n++;
      if (rsp_valid) begin got = 1; tk_lat = k; tk_data = rsp_data; tk_err = rsp_err; end
    end
    if (!got) begin tk_timeout = 1; return; end
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== tk_data || rsp_err !== tk_err) tk_stable = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    tk_idle = !rsp_valid && cmd_ready;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [63:0] data;
    int          hold;
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          n_iwe, n_dwe, n_dre, n_low;
    logic [9:0]  saddr;
    logic [63:0] swdata;
  } vec_t;

  vec_t vecs[16];

  localparam logic [63:0] RESULT_EXP = -64'sd18700;
  logic [31:0] prog [13];
  logic [63:0] vals [6];

  initial begin
    // op, addr, data, hold, err, rdata, lat, iwe, dwe, dre, low, saddr, swdata
    vecs[0]  = '{OP_NOP,     16'h0000, 64'h0, 0, 1'b0, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[1]  = '{OP_WR_IMEM, 16'h000C, 64'h8C0B0018, 0, 1'b0, 64'h0, 2, 1,0,0,0, 10'd3, 64'h8C0B0018};
    vecs[2]  = '{OP_WR_DMEM, 16'h0028, 64'h3, 0, 1'b0, 64'h0, 2, 0,1,0,0, 10'd5, 64'h3};
    vecs[3]  = '{OP_RD_DMEM, 16'h0028, 64'h0, 5, 1'b0, 64'h3, 3, 0,0,1,0, 10'd5, 64'h0};
    vecs[4]  = '{OP_WR_DMEM, 16'h000C, 64'h55, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[5]  = '{OP_RD_DMEM, 16'h0200, 64'h0, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[6]  = '{3'd6,       16'h0000, 64'h0, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[7]  = '{3'd7,       16'h0010, 64'h7, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[8]  = '{OP_WR_IMEM, 16'h000E, 64'h1, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[9]  = '{OP_WR_IMEM, 16'h0100, 64'h1, 0, 1'b1, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[10] = '{OP_WR_IMEM, 16'h00FC, 64'hFFFFFFFF12345678, 0, 1'b0, 64'h0, 2, 1,0,0,0, 10'd63, 64'h12345678};
    vecs[11] = '{OP_WR_DMEM, 16'h01F8, 64'hDEADBEEF01234567, 0, 1'b0, 64'h0, 2, 0,1,0,0, 10'd63, 64'hDEADBEEF01234567};
    vecs[12] = '{OP_RD_DMEM, 16'h01F8, 64'h0, 2, 1'b0, 64'hDEADBEEF01234567, 3, 0,0,1,0, 10'd63, 64'h0};
    vecs[13] = '{OP_RUN,     16'h0000, 64'h0, 0, 1'b0, 64'h0, 1, 0,0,0,0, 10'd0, 64'h0};
    vecs[14] = '{OP_RUN,     16'h0000, 64'h3, 1, 1'b0, 64'h3, 4, 0,0,0,3, 10'd0, 64'h0};
    vecs[15] = '{OP_RUN,     16'h0000, 64'hFFFF000000000002, 0, 1'b0, 64'h2, 3, 0,0,0,2, 10'd0, 64'h0};

    prog = '{32'h8C080000, 32'h8C090028, 32'h01090018, 32'h00005012,
             32'h8C0B0018, 32'h8C0C0020, 32'h016C0018, 32'h00006812,
             32'h014D7020, 32'h8C0F0010, 32'h01CF7020, 32'hAC0E0030,
             32'h1000FFFF};
    vals = '{-64'sd1000, 64'sd200, 64'sd300, -64'sd400, 64'sd40, 64'sd3};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_strobes", {imem_we, dmem_we, dmem_re}, 3'b000);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_cpu_reset", cpu_reset, 1'b1);

    // ---- table ----
    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].hold, 30);
      chk($sformatf("v%0d_timeout", i), tk_timeout, 1'b0);
      chk($sformatf("v%0d_err", i), tk_err, vecs[i].err);
      chk($sformatf("v%0d_data", i), tk_data, vecs[i].rdata);
      chk($sformatf("v%0d_lat", i), tk_lat, vecs[i].lat);
      chk($sformatf("v%0d_iwe", i), tk_iwe_n, vecs[i].n_iwe);
      chk($sformatf("v%0d_dwe", i), tk_dwe_n, vecs[i].n_dwe);
      chk($sformatf("v%0d_dre", i), tk_dre_n, vecs[i].n_dre);
      chk($sformatf("v%0d_low", i), tk_low_n, vecs[i].n_low);
      chk($sformatf("v%0d_stable", i), tk_stable, 1'b1);
      chk($sformatf("v%0d_idle", i), tk_idle, 1'b1);
      if (vecs[i].n_iwe + vecs[i].n_dwe + vecs[i].n_dre > 0) begin
        chk($sformatf("v%0d_scyc", i), tk_scyc, 1);
        chk($sformatf("v%0d_saddr", i), tk_saddr, vecs[i].saddr);
        if (vecs[i].n_dre == 0)
          chk($sformatf("v%0d_swdata", i), tk_swdata, vecs[i].swdata);
      end
    end
    chk("imem3", imem[3], 32'h8C0B0018);

    // ---- program load, run 14, readback ----
    for (int i = 0; i < 13; i++) begin
      run_cmd(OP_WR_IMEM, 16'(i * 4), {32'd0, prog[i]}, 0, 30);
      chk($sformatf("prog%0d_err", i), tk_err, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      run_cmd(OP_WR_DMEM, 16'(i * 8), vals[i], 0, 30);
      chk($sformatf("data%0d_err", i), tk_err, 1'b0);
    end
    run_cmd(OP_WR_DMEM, 16'd48, 64'h0, 0, 30);
    for (int i = 0; i < 13; i++) chk($sformatf("imem%0d", i), imem[i], prog[i]);
    run_cmd(OP_RUN, 16'h0, 64'd14, 0, 40);
    chk("run14_timeout", tk_timeout, 1'b0);
    chk("run14_low", tk_low_n, 14);
    chk("run14_lat", tk_lat, 15);
    chk("run14_data", tk_data, 64'd14);
    run_cmd(OP_RD_DMEM, 16'd48, 64'h0, 0, 30);
    chk("result", tk_data, RESULT_EXP);

    // ---- reset during RUN 100 ----
    @(negedge clk);
    chk("mr_ready", cmd_ready, 1'b1);
    cmd_op = OP_RUN; cmd_addr = '0; cmd_data = 64'd100; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_running", cpu_reset, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cpu_reset", cpu_reset, 1'b1);
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_state", dbg_state, S_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_ready", cmd_ready, 1'b1);
    begin
      int seen = 0;
      repeat (110) begin
        @(negedge clk);
        if (rsp_valid || !cpu_reset) seen++;
      end
      chk("mr_no_resp", seen, 0);
    end
    run_cmd(OP_NOP, 16'h0, 64'h0, 0, 30);
    chk("mr_nop_timeout", tk_timeout, 1'b0);
    chk("mr_nop_lat", tk_lat, 1);
    chk("mr_nop_err", tk_err, 1'b0);
    run_cmd(OP_RD_DMEM, 16'd48, 64'h0, 0, 30);
    chk("mr_mem_kept", tk_data, RESULT_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
